pwm_capture_3bit: RTL

Receive-side counterpart of the 3-bit PWM generator. Samples an incoming PWM waveform and recovers its duty value as a high-cycle count per period. Flags periods that differ from the nominal 2^WIDTH clocks, and flags inputs stuck at 0% or 100%. Sits on the far end of a PWM link, or loops back a generator output for self-check; runs on the same `Clock`/`CE` timebase as the generator.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_in_sync.sv | 33 +++
 rtl/pwm_capture_3bit.sv | 113 +++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and FSM encoding for the PWM generator/capture pair.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH   = 3;
    localparam int unsigned PWM_PERIOD  = 2 ** PWM_WIDTH;
    localparam int unsigned PWM_TIMEOUT = 2 * PWM_PERIOD;

    typedef enum logic [1:0] {
        PWM_IDLE    = 2'd0,
        PWM_MEASURE = 2'd1,
        PWM_STUCK   = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer for the PWM input plus CE-gated rising-edge detector.
module pwm_in_sync (
    input  logic clk_i,
    input  logic clr_ni,
    input  logic ce_i,
    input  logic pwm_i,
    output logic level_o,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // s1/s2 run every clock; s3 only advances on CE so edges are seen in CE-cycles.
    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pwm_i;
            s2_q <= s1_q;
            if (ce_i) begin
                s3_q <= s2_q;
            end
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q & ce_i;

endmodule

// File: rtl/pwm_capture_3bit.sv
// PWM receiver: recovers the duty count per period and flags period errors and stuck inputs.
module pwm_capture_3bit
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH   = PWM_WIDTH,
    parameter int unsigned TIMEOUT = 2 ** (WIDTH + 1)
) (
    input  logic             Clock,
    input  logic             CLR_N,
    input  logic             CE,
    input  logic             PWM_IN,
    output logic [WIDTH:0]   DUTY,
    output logic             VALID,
    output logic             PERIOD_ERR,
    output logic             STUCK
);

    localparam int unsigned CW = WIDTH + 2;

    localparam logic [CW-1:0]  CNT_MAX   = '1;
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  PERIOD    = CW'(2 ** WIDTH);
    localparam logic [CW-1:0]  TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [WIDTH:0] DUTY_FULL = (WIDTH + 1)'(2 ** WIDTH);

    logic level;
    logic rise;

    pwm_in_sync u_sync (
        .clk_i   (Clock),
        .clr_ni  (CLR_N),
        .ce_i    (CE),
        .pwm_i   (PWM_IN),
        .level_o (level),
        .rise_o  (rise)
    );

    pwm_state_e     state_q, state_d;
    logic [CW-1:0]  per_q, per_d;
    logic [CW-1:0]  hi_q, hi_d;
    logic [WIDTH:0] duty_q, duty_d;
    logic           valid_q, valid_d;
    logic           perr_q, perr_d;
    logic           stuck_q, stuck_d;

    always_ff @(posedge Clock) begin
        if (!CLR_N) begin
            state_q <= PWM_IDLE;
            per_q   <= '0;
            hi_q    <= '0;
            duty_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            hi_q    <= hi_d;
            duty_q  <= duty_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            stuck_q <= stuck_d;
        end
    end

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        hi_d    = hi_q;
        duty_d  = duty_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        stuck_d = stuck_q;

        if (CE) begin
            if (rise) begin
                per_d   = CNT_ONE;
                hi_d    = CNT_ONE;
                state_d = PWM_MEASURE;
                case (state_q)
                    PWM_MEASURE: begin
                        duty_d  = (hi_q > PERIOD) ? DUTY_FULL : hi_q[WIDTH:0];
                        perr_d  = (per_q != PERIOD);
                        valid_d = 1'b1;
                    end
                    PWM_STUCK: stuck_d = 1'b0;
                    default: ;
                endcase
            end else begin
                if (per_q != CNT_MAX) begin
                    per_d = per_q + CNT_ONE;
                end
                if (level && (hi_q != CNT_MAX)) begin
                    hi_d = hi_q + CNT_ONE;
                end
                // Report the stuck level once; further publishes wait for a fresh edge.
                if ((state_q != PWM_STUCK) && (per_q == TO_LAST)) begin
                    state_d = PWM_STUCK;
                    duty_d  = level ? DUTY_FULL : '0;
                    valid_d = 1'b1;
                    stuck_d = 1'b1;
                    perr_d  = 1'b0;
                end
            end
        end
    end

    assign DUTY       = duty_q;
    assign VALID      = valid_q;
    assign PERIOD_ERR = perr_q;
    assign STUCK      = stuck_q;

endmodule
